// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared widths, ALU op encodings and execute-stage FSM state codes.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int OP_W    = 3;
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [OP_W-1:0] ALU_AND = 3'd0;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [OP_W-1:0] ALU_XOR = 3'd2;
  localparam logic [OP_W-1:0] ALU_ADD = 3'd3;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd4;
  localparam logic [OP_W-1:0] ALU_SLL = 3'd5;
  localparam logic [OP_W-1:0] ALU_SRL = 3'd6;
  localparam logic [OP_W-1:0] ALU_SLT = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Shifts are the only ops that may take more than one cycle.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction
endpackage
`default_nettype wire

// File: rtl/alu_ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ex_stage_if                                                      |
// | Operand-in / result-out valid-ready bundle of the execute stage.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_ex_stage_if #(
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int RADDR_W = alu_pkg::RADDR_W
) ();
  import alu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_op;
  logic [XLEN-1:0]    in_rs1;
  logic [XLEN-1:0]    in_rs2;
  logic [RADDR_W-1:0] in_rd_addr;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [RADDR_W-1:0] out_rd_addr;
  logic               out_zero;

  // Upstream/downstream side: drives operands and result acceptance.
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd_addr, out_ready,
    input  in_ready, out_valid, out_result, out_rd_addr, out_zero
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd_addr, out_ready,
    output in_ready, out_valid, out_result, out_rd_addr, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_and.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_and                                                              |
// | Bitwise AND function unit.                                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_and #(
  parameter int W = 32
) (
  input  wire logic [W-1:0] i_a,
  input  wire logic [W-1:0] i_b,
  output logic      [W-1:0] o_y
);
  assign o_y = i_a & i_b;
endmodule
`default_nettype wire

// File: rtl/alu_shift_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_shift_seq                                                        |
// | Serial 1-bit/cycle logical shifter with a remaining-step counter.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_shift_seq #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_load,   // capture operand, amount and direction
  input  wire logic          i_dir,    // 1 = logical right, 0 = left
  input  wire logic [W-1:0]  i_data,
  input  wire logic [SW-1:0] i_shamt,
  input  wire logic          i_step,   // advance one bit position
  output logic      [W-1:0]  o_acc_next,
  output logic               o_done    // the coming step is the last one
);
  logic [W-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic          r_dir;

  assign o_acc_next = r_dir ? (r_acc >> 1) : (r_acc << 1);
  assign o_done     = (r_cnt == SW'(1));

  // Load a new shift or move the accumulator one position per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_data;
      r_cnt <= i_shamt;
      r_dir <= i_dir;
    end else if (i_step && (r_cnt != '0)) begin
      r_acc <= o_acc_next;
      r_cnt <= r_cnt - SW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_ex_stage                                                         |
// | Execute stage: single-cycle logic/arith ops, serial shifts, and a    |
// | registered result delivered over a valid/ready handshake.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_ex_stage #(
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int RADDR_W = alu_pkg::RADDR_W
) (
  input wire logic      clk,
  input wire logic      rst,
  alu_ex_stage_if.slave bus
);
  import alu_pkg::*;

  localparam int SW = $clog2(XLEN);

  logic [1:0]         r_state;
  logic [XLEN-1:0]    r_result;
  logic [RADDR_W-1:0] r_rd;
  logic               r_zero;

  logic               w_in_ready;
  logic               w_accept;
  logic [SW-1:0]      w_shamt;
  logic               w_start_shift;
  logic [XLEN-1:0]    w_and;
  logic [XLEN-1:0]    w_res;
  logic [XLEN-1:0]    w_acc_next;
  logic               w_shift_done;

  // Ready depends only on state and downstream ready, never on in_valid.
  assign w_in_ready    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_shamt       = bus.in_rs2[SW-1:0];
  assign w_start_shift = w_accept && is_shift(bus.in_op) && (w_shamt != '0);

  alu_and #(.W(XLEN)) u_and (
    .i_a (bus.in_rs1),
    .i_b (bus.in_rs2),
    .o_y (w_and)
  );

  // Single-cycle result; a zero-amount shift simply returns rs1.
  always_comb begin
    w_res = bus.in_rs1;
    case (bus.in_op)
      ALU_AND: w_res = w_and;
      ALU_OR:  w_res = bus.in_rs1 | bus.in_rs2;
      ALU_XOR: w_res = bus.in_rs1 ^ bus.in_rs2;
      ALU_ADD: w_res = bus.in_rs1 + bus.in_rs2;
      ALU_SUB: w_res = bus.in_rs1 - bus.in_rs2;
      ALU_SLT: w_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_rs1) < $signed(bus.in_rs2))};
      default: w_res = bus.in_rs1;
    endcase
  end

  alu_shift_seq #(.W(XLEN), .SW(SW)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start_shift),
    .i_dir      (bus.in_op == ALU_SRL),
    .i_data     (bus.in_rs1),
    .i_shamt    (w_shamt),
    .i_step     (r_state == ST_SHIFT),
    .o_acc_next (w_acc_next),
    .o_done     (w_shift_done)
  );

  // Stage FSM and result registers; HOLD re-accepts on the same edge it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_rd     <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            r_rd <= bus.in_rd_addr;
            if (w_start_shift) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state  <= ST_HOLD;
              r_result <= w_res;
              r_zero   <= (w_res == '0);
            end
          end else if ((r_state == ST_HOLD) && bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_shift_done) begin
            r_state  <= ST_HOLD;
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == ST_HOLD);
  assign bus.out_result  = r_result;
  assign bus.out_rd_addr = r_rd;
  assign bus.out_zero    = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_ex_stage                                                      |
// | Scoreboard bench: driver pushes model results, monitor pops/compares.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_ex_stage;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic clk;
  logic rst;
  alu_ex_stage_if bus ();

  alu_ex_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        q[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  int          hs_cnt   = 0;
  bit          rdy_rand = 0;
  bit          stall_pend = 0;
  logic [31:0] s_res;
  logic [4:0]  s_rd;
  logic        s_zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour straight from the op definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a + b;
      3'd4: return a - b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Present one op (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int waited);
    exp_t e;
    waited = 0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs1 = a; bus.in_rs2 = b; bus.in_rd_addr = rd;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (bus.in_ready) begin
      e.res = model(op, a, b);
      e.rd  = rd;
      q.push_back(e);
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the stage must ignore them.
    bus.in_valid = 1'b0; bus.in_op = 3'($urandom); bus.in_rs1 = $urandom; bus.in_rs2 = $urandom;
    bus.in_rd_addr = 5'($urandom);
  endtask

  // Count cycles until out_valid and check in_ready stayed low meanwhile.
  task automatic lat_check(input int exp_lat, input string nm);
    int n = 0;
    int rdy_seen = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      if (bus.in_ready) rdy_seen++;
      n++;
      @(negedge clk);
    end
    chk(nm, n, exp_lat);
    if (exp_lat > 0) chk({nm, "_inready_low"}, rdy_seen, 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare each handshaken output and check stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_result", bus.out_result, s_res);
        chk("hold_rd", {27'd0, bus.out_rd_addr}, {27'd0, s_rd});
        chk("hold_zero", {31'd0, bus.out_zero}, {31'd0, s_zero});
        stall_pend = 0;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            chk("unexpected_output", bus.out_result, 32'hxxxx_xxxx);
          end else begin
            e = q.pop_front();
            chk("result", bus.out_result, e.res);
            chk("rd_addr", {27'd0, bus.out_rd_addr}, {27'd0, e.rd});
            chk("zero", {31'd0, bus.out_zero}, {31'd0, (e.res == 32'd0)});
          end
        end else begin
          stall_pend = 1;
          s_res  = bus.out_result;
          s_rd   = bus.out_rd_addr;
          s_zero = bus.out_zero;
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) bus.out_ready = (($urandom % 4) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int cnt;
    int h0;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_rd_addr = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_rd", {27'd0, bus.out_rd_addr}, 32'd0);
    chk("rst_zero", {31'd0, bus.out_zero}, 32'd1);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a long shift discards it.
    issue(ALU_SLL, 32'd1, 32'd20, 5'd9, w);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("abort_no_result", cnt, 0);
    @(posedge clk); #1;

    // Single-cycle ops.
    issue(ALU_AND, 32'hFFFF_FFFF, 32'h0F0F_00FF, 5'd5, w); lat_check(0, "lat_and");
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd1, w);         lat_check(0, "lat_add");
    issue(ALU_SUB, 32'd0, 32'd1, 5'd2, w);                 lat_check(0, "lat_sub");
    issue(ALU_SLT, 32'h8000_0000, 32'd1, 5'd3, w);         lat_check(0, "lat_slt_a");
    issue(ALU_SLT, 32'd1, 32'h8000_0000, 5'd0, w);         lat_check(0, "lat_slt_b");
    issue(ALU_OR,  32'hA5A5_0000, 32'h0000_5A5A, 5'd7, w); lat_check(0, "lat_or");
    issue(ALU_XOR, 32'h1234_5678, 32'h1234_5678, 5'd8, w); lat_check(0, "lat_xor");

    // Shifts: latency equals shift amount; zero amount is single-cycle.
    issue(ALU_SLL, 32'd1, 32'd31, 5'd11, w);                lat_check(31, "lat_sll31");
    issue(ALU_SRL, 32'h8000_00F0, 32'h23, 5'd12, w);        lat_check(3, "lat_srl3");
    issue(ALU_SRL, 32'hDEAD_BEEF, 32'h20, 5'd13, w);        lat_check(0, "lat_srl0");

    // Backpressure: result held while next op waits with in_valid high.
    issue(ALU_ADD, 32'd100, 32'd23, 5'd14, w);
    bus.out_ready = 1'b0;
    fork
      issue(ALU_XOR, 32'hFFFF_0000, 32'h00FF_FF00, 5'd15, w);
      begin
        repeat (4) begin
          @(negedge clk); #1;
          chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    chk("bp_wait_cycles", w, 4);
    repeat (3) @(posedge clk);
    #1;

    // Streaming: eight single-cycle ops, one per cycle.
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      issue((i % 2 == 0) ? ALU_AND : ALU_ADD, $urandom, $urandom, 5'(i + 16), w);
      chk("stream_no_wait", w, 0);
    end
    @(negedge clk); #1;
    chk("stream_results", hs_cnt - h0, 8);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and gaps.
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (($urandom % 4) == 0) a = {1'b1, 31'($urandom)};
      issue(op, a, b, 5'($urandom), w);
      if (($urandom % 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Drain.
    rdy_rand = 0;
    bus.out_ready = 1'b1;
    cnt = 0;
    while (q.size() != 0 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
`default_nettype wire
